// File: rtl/stream_upsizer_arbiter_if.sv
// ---------------------------------------------------------------------------
// stream_upsizer_arbiter_if
// Bundles the N requester streams and the single upsizer-facing stream of the
// stream_upsizer_arbiter.
//   s_data_i  [N*DW]  requester data, requester k in bits [k*DW +: DW]
//   s_valid_i [N]     per-requester valid
//   s_ready_o [N]     per-requester ready
//   m_data_o  [DW]    beat towards the upsizer
//   m_valid_o         beat valid towards the upsizer
//   m_ready_i         upsizer ready
//   m_id_o    [IW]    granted requester index, stable for a whole group
//   m_last_o          last (SCALE-th) beat of the group
// Modports:
//   master - the arbiter's view (drives the upsizer side and requester readies)
//   slave  - the surrounding logic's view (requesters plus upsizer)
// ---------------------------------------------------------------------------
interface stream_upsizer_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 8
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;

    logic [N*DW-1:0] s_data_i;
    logic [N-1:0]    s_valid_i;
    logic [N-1:0]    s_ready_o;
    logic [DW-1:0]   m_data_o;
    logic            m_valid_o;
    logic            m_ready_i;
    logic [IW-1:0]   m_id_o;
    logic            m_last_o;

    modport master (
        input  s_data_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o
    );

    modport slave (
        output s_data_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o
    );
endinterface

// File: rtl/stream_upsizer_arbiter.sv
// ---------------------------------------------------------------------------
// stream_upsizer_arbiter
// N-to-1 round-robin stream arbiter feeding a shared SCALE:1 upsizer. A grant
// is held for exactly SCALE accepted beats so every packed word comes from a
// single source. Data/valid of the granted channel pass through unregistered.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    stream_upsizer_arbiter_if.master (requester and upsizer streams)
// ---------------------------------------------------------------------------
module stream_upsizer_arbiter #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int SCALE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_upsizer_arbiter_if.master bus
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam int CW = $clog2(SCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCALE - 1);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;

    logic          sel_valid;
    logic [DW-1:0] sel_data;
    logic          m_valid;
    logic [N-1:0]  s_ready;

    // First valid requester searching upward from ptr+1, wrapping modulo N.
    // Iterating from the farthest candidate down leaves the nearest one.
    function automatic logic [IW-1:0] rr_next(input logic [N-1:0] valid,
                                              input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (valid[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    // Granted channel mux; written as a compare loop so non-power-of-two N
    // never indexes past the vectors.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q == IW'(k)) begin
                sel_valid = bus.s_valid_i[k];
                sel_data  = bus.s_data_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        m_valid = 1'b0;
        s_ready = '0;
        case (state_q)
            IDLE: begin
                if (|bus.s_valid_i) begin
                    gnt_d   = rr_next(bus.s_valid_i, last_q);
                    cnt_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                m_valid = sel_valid;
                for (int k = 0; k < N; k++) begin
                    if (gnt_q == IW'(k)) s_ready[k] = bus.m_ready_i;
                end
                if (sel_valid && bus.m_ready_i) begin
                    if (cnt_q == CNT_LAST) begin
                        // Group complete: re-arbitrate in the same cycle so
                        // back-to-back groups have no bubble.
                        cnt_d  = '0;
                        last_d = gnt_q;
                        if (|bus.s_valid_i) begin
                            gnt_d = rr_next(bus.s_valid_i, gnt_q);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.m_data_o  = sel_data;
    assign bus.m_valid_o = m_valid;
    assign bus.s_ready_o = s_ready;
    assign bus.m_id_o    = gnt_q;
    assign bus.m_last_o  = (state_q == LOCK) && (cnt_q == CNT_LAST);

endmodule
